// File: rtl/csa_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder/subtractor.
package csa_pkg;
  localparam int CSA_WIDTH = 16;
  localparam int CSA_BLOCK = 4;

  // Number of carry-select slices, which is also the pipeline depth.
  function automatic int nb(input int width, input int block);
    return width / block;
  endfunction
endpackage

// File: rtl/csa_slice.sv
// One BLOCK-bit carry-select slice: two ripple adders, one per assumed carry-in.
module csa_slice import csa_pkg::*; #(
  parameter int BLOCK = CSA_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic             cout0,
  output logic             cmsb0,
  output logic [BLOCK-1:0] sum1,
  output logic             cout1,
  output logic             cmsb1
);
  logic [BLOCK:0] c0, c1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    sum0  = '0;
    sum1  = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      sum0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1]   = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      sum1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1]   = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  // cmsb is the carry into the slice MSB, needed for signed overflow.
  assign cout0 = c0[BLOCK];
  assign cmsb0 = c0[BLOCK-1];
  assign cout1 = c1[BLOCK];
  assign cmsb1 = c1[BLOCK-1];
endmodule

// File: rtl/csa_pipe_addsub.sv
// Pipelined carry-select add/sub: one slice resolved per stage, whole-pipe stall
// on backpressure, NB = WIDTH/BLOCK cycles of latency.
module csa_pipe_addsub import csa_pkg::*; #(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLOCK = CSA_BLOCK
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NB = nb(WIDTH, BLOCK);

  if (WIDTH % BLOCK != 0) begin : g_bad_cfg
    $fatal(1, "csa_pipe_addsub: WIDTH must be a multiple of BLOCK");
  end

  logic          stall, adv;
  logic [NB:1]   vld_pipe;

  assign stall     = out_valid && !out_ready;
  assign adv       = !stall;
  assign in_ready  = !stall;
  assign out_valid = vld_pipe[NB];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= NB; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Stage s resolves slice s; operand bits above it and sum bits below it ride along.
  for (genvar s = 0; s < NB; s++) begin : g_stg
    localparam int W_IN = WIDTH - s*BLOCK;

    logic [W_IN-1:0]          ra, rb;
    logic                     ci;
    logic [BLOCK-1:0]         s0, s1, sel;
    logic                     k0, k1, m0, m1, csel;
    logic [(s+1)*BLOCK-1:0]   sum_d, sum_q;
    logic                     c_q;

    csa_slice #(.BLOCK(BLOCK)) u_slice (
      .a(ra[BLOCK-1:0]), .b(rb[BLOCK-1:0]),
      .sum0(s0), .cout0(k0), .cmsb0(m0),
      .sum1(s1), .cout1(k1), .cmsb1(m1)
    );

    assign sel  = ci ? s1 : s0;
    assign csel = ci ? k1 : k0;

    if (s == 0) begin : g_src
      assign ra    = a;
      assign rb    = sub ? ~b : b;
      assign ci    = sub | cin;
      assign sum_d = sel;
    end else begin : g_src
      assign ra    = g_stg[s-1].g_fwd.ra_q;
      assign rb    = g_stg[s-1].g_fwd.rb_q;
      assign ci    = g_stg[s-1].c_q;
      assign sum_d = {sel, g_stg[s-1].sum_q};
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        sum_q <= sum_d;
        c_q   <= csel;
      end
    end

    if (s < NB-1) begin : g_fwd
      logic [W_IN-BLOCK-1:0] ra_q, rb_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (adv) begin
          ra_q <= ra[W_IN-1:BLOCK];
          rb_q <= rb[W_IN-1:BLOCK];
        end
      end
    end else begin : g_last
      logic cm_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)    cm_q <= 1'b0;
        else if (adv) cm_q <= ci ? m1 : m0;
      end
    end
  end

  assign sum  = g_stg[NB-1].sum_q;
  assign cout = g_stg[NB-1].c_q;
  assign ovf  = g_stg[NB-1].c_q ^ g_stg[NB-1].g_last.cm_q;
endmodule

// File: tb/tb_csa_pipe_addsub.sv
// Bench for csa_pipe_addsub: 16/4 directed + backpressure + reset, 32/8 and 8/8 random.
module tb_csa_pipe_addsub;
  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;

  logic        iv16 = 0, ir16, ov16, or16 = 1, cin16 = 0, sub16 = 0, co16, ovf16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        iv32 = 0, ir32, ov32, or32 = 1, cin32 = 0, sub32 = 0, co32, ovf32;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        iv8 = 0, ir8, ov8, or8 = 1, cin8 = 0, sub8 = 0, co8, ovf8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;

  csa_pipe_addsub #(.WIDTH(16), .BLOCK(4)) u16 (
    .clock(clock), .reset(reset), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(co16), .ovf(ovf16));
  csa_pipe_addsub #(.WIDTH(32), .BLOCK(8)) u32 (
    .clock(clock), .reset(reset), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .cout(co32), .ovf(ovf32));
  csa_pipe_addsub #(.WIDTH(8), .BLOCK(8)) u8 (
    .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(co8), .ovf(ovf8));

  // Expected beats are packed {ovf, cout, sum[31:0]}.
  logic [33:0] q16[$], q32[$], q8[$];
  logic [33:0] e16, e32, e8;
  vec_t        tbl[10];
  vec_t        bpv;
  bit          done32 = 0, done8 = 0;
  bit          acc;

  task automatic check1(input string nm, input logic [33:0] got, input logic [33:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb);
    logic [32:0] t;
    logic [31:0] m, ye, s;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ye = (sb ? ~y : y) & m;
    t  = {1'b0, x & m} + {1'b0, ye} + {32'd0, (sb ? 1'b1 : ci)};
    s  = t[31:0] & m;
    return {((x[w-1] == ye[w-1]) && (s[w-1] != x[w-1])), t[w], s};
  endfunction

  always @(negedge clock) if (!reset && ov16 && or16) begin
    if (q16.size() == 0) check1("out16_spurious", {ovf16, co16, 16'h0, sum16}, 34'h3_FFFF_FFFF);
    else begin e16 = q16.pop_front(); check1("out16", {ovf16, co16, 16'h0, sum16}, e16); end
  end
  always @(negedge clock) if (!reset && ov32 && or32) begin
    if (q32.size() == 0) check1("out32_spurious", {ovf32, co32, sum32}, 34'h3_FFFF_FFFF);
    else begin e32 = q32.pop_front(); check1("out32", {ovf32, co32, sum32}, e32); end
  end
  always @(negedge clock) if (!reset && ov8 && or8) begin
    if (q8.size() == 0) check1("out8_spurious", {ovf8, co8, 24'h0, sum8}, 34'h3_FFFF_FFFF);
    else begin e8 = q8.pop_front(); check1("out8", {ovf8, co8, 24'h0, sum8}, e8); end
  end

  // Holds the beat on the inputs until accepted; the expected result is queued at acceptance.
  task automatic send16(input vec_t v);
    bit ok;
    ok = 0;
    a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub; iv16 = 1'b1;
    for (int w = 0; w < 100 && !ok; w++) begin
      @(negedge clock);
      ok = ir16;
      if (ok) q16.push_back({v.ov, v.co, 16'h0, v.s});
      @(posedge clock); #1;
    end
    if (!ok) check1("send16_timeout", 34'd0, 34'd1);
    iv16 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    nerr++;
    $display("Result: errors=%0d of %0d checks", nerr, nchk + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[8] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[9] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check1("rst_out_valid", {33'h0, ov16}, 34'h0);
    check1("rst_sum", {18'h0, sum16}, 34'h0);
    check1("rst_cout", {33'h0, co16}, 34'h0);
    check1("rst_ovf", {33'h0, ovf16}, 34'h0);
    check1("rst_in_ready", {33'h0, ir16}, 34'h1);

    // Lone beat: out_valid must rise on the 4th edge counting the accepting one.
    @(posedge clock); #1;
    send16(tbl[0]);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check1("latency", {33'h0, ov16}, {33'h0, (k == 4)});
    end
    @(posedge clock); #1;
    for (int i = 1; i < 10; i++) send16(tbl[i]);
    repeat (8) @(negedge clock);
    check1("tbl_drain", 34'(q16.size()), 34'h0);

    // Backpressure: 6 back-to-back beats, 3-cycle stall once the first result shows.
    @(posedge clock); #1;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          bpv = '{16'(i), 16'h0010, 1'b0, 1'b0, 16'h0010 + 16'(i), 1'b0, 1'b0};
          send16(bpv);
        end
      end
      begin
        acc = 0;
        for (int w = 0; w < 50 && !acc; w++) begin
          @(posedge clock); #1;
          acc = ov16;
        end
        if (!acc) check1("bp_first_timeout", 34'd0, 34'd1);
        or16 = 1'b0;
        repeat (3) begin
          @(negedge clock);
          check1("stall_ready", {33'h0, ir16}, 34'h0);
          check1("stall_hold", {ovf16, co16, ov16, 15'h0, sum16}, {3'b001, 15'h0, 16'h0011});
          @(posedge clock);
        end
        #1 or16 = 1'b1;
      end
    join
    repeat (8) @(negedge clock);
    check1("bp_drain", 34'(q16.size()), 34'h0);

    // Asynchronous reset with three beats in flight.
    @(posedge clock); #1;
    for (int i = 4; i < 7; i++) send16(tbl[i]);
    #2 reset = 1'b1;
    #1 check1("rst_mid_out", {ovf16, co16, ov16, 15'h0, sum16}, 34'h0);
    q16.delete();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock) reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      check1("rst_mid_stale", {33'h0, ov16}, 34'h0);
    end

    // Random beats with random backpressure on the 32/8 and 8/8 configurations.
    @(posedge clock); #1;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          bit ok;
          ok = 0;
          a32 = $urandom; b32 = $urandom;
          cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
          iv32 = 1'b1;
          for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clock);
            ok = ir32;
            if (ok) q32.push_back(model(32, a32, b32, cin32, sub32));
            @(posedge clock); #1;
          end
          if (!ok) check1("send32_timeout", 34'd0, 34'd1);
          iv32 = 1'b0;
          if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
        end
        done32 = 1;
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          bit ok;
          ok = 0;
          a8 = 8'($urandom); b8 = 8'($urandom);
          cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
          iv8 = 1'b1;
          for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clock);
            ok = ir8;
            if (ok) q8.push_back(model(8, {24'h0, a8}, {24'h0, b8}, cin8, sub8));
            @(posedge clock); #1;
          end
          if (!ok) check1("send8_timeout", 34'd0, 34'd1);
          iv8 = 1'b0;
          if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
        end
        done8 = 1;
      end
      begin
        while (!(done32 && done8)) begin
          @(posedge clock); #1;
          or32 = 1'($urandom_range(0, 1));
          or8  = 1'($urandom_range(0, 1));
        end
      end
    join
    or32 = 1'b1;
    or8  = 1'b1;
    for (int w = 0; w < 100 && (q32.size() != 0 || q8.size() != 0); w++) @(negedge clock);
    check1("rand32_drain", 34'(q32.size()), 34'h0);
    check1("rand8_drain", 34'(q8.size()), 34'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
